fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, address of the first fetch after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clock is clk.
REQ-004 stall  input  1  downstream IF/ID stage cannot accept; output slot holds.
REQ-005 redirect_valid  input  1  branch/jump resolved downstream; restart fetch.
REQ-006 redirect_pc  input  64  target address for redirect_valid.
REQ-007 imem_req_valid  output  1  instruction memory request.
REQ-008 imem_req_ready  input  1  memory accepts request this cycle.
REQ-009 imem_addr  output  64  request address, stable while imem_req_valid && !imem_req_ready.
REQ-010 imem_resp_valid  input  1  response data valid, exactly one per accepted request, at least 1 cycle after acceptance.
REQ-011 imem_resp_data  input  32  fetched instruction.
REQ-012 if_valid  output  1  if_pc/if_instr hold a fetched instruction.
REQ-013 if_pc  output  64  address of if_instr.
REQ-014 if_instr  output  32  instruction delivered to IF/ID register.
REQ-015 if_pred_taken  output  1  fetch predicted this instruction taken.

Function
REQ-016 FSM states: REQ (imem_req_valid=1, imem_addr=fetch_pc), WAIT (one request outstanding), SKID (response parked, no request issued).
REQ-017 REQ -> WAIT on imem_req_valid && imem_req_ready; otherwise stay in REQ with address stable.
REQ-018 At most one request outstanding; imem_req_valid=0 in WAIT and SKID.
REQ-019 Output slot transfer: instruction consumed when if_valid && !stall; slot free when !if_valid || !stall.
REQ-020 WAIT, response arrives, slot free: if_instr<=data, if_pc<=fetch_pc, if_valid<=1, fetch_pc<=next_pc, state -> REQ (new request issued the cycle after response).
REQ-021 WAIT, response arrives, slot occupied (if_valid && stall): data and PC captured in skid register, state -> SKID.
REQ-022 SKID -> REQ on first cycle with !stall: skid contents move to output slot, fetch_pc<=next_pc.
REQ-023 No response in a cycle the slot is free: if_valid<=0.
REQ-024 next_pc = fetch_pc + 4 (modulo 2^64) unless REQ-036 applies; if_pred_taken=0 otherwise.
REQ-025 redirect_valid has priority over every other event in the same cycle: if_valid<=0, skid emptied, fetch_pc<=redirect_pc, state -> REQ next cycle.
REQ-026 Redirect during WAIT: kill flag set; the pending response is discarded on arrival, then REQ to redirect_pc; response arriving in the same cycle as redirect is discarded.
REQ-027 Redirect during REQ with imem_req_ready=1 in that cycle: request counts as accepted, its response discarded per REQ-026.
REQ-028 Redirect with odd/misaligned redirect_pc: used unchanged (alignment is the redirecting stage's responsibility).

Reset
REQ-029 reset asserted: fetch_pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_instr=0, if_pred_taken=0, skid empty, kill flag=0.
REQ-030 imem_req_valid=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-031 Reset mid-WAIT: outstanding response is not tracked; memory is reset by the same signal and issues no stale response.

Configuration
REQ-032 Macro FETCH_BTFN_PREDICT_EN selects static backward-taken/forward-not-taken prediction.
REQ-033 Without the macro: next_pc always fetch_pc+4, if_pred_taken tied 0, no decode logic present.
REQ-034 With the macro, JAL (opcode 1101111): next_pc = pc + sign-extended J-immediate, if_pred_taken=1.
REQ-035 With the macro, conditional branch (opcode 1100011) with instr[31]=1: next_pc = pc + sign-extended B-immediate, if_pred_taken=1.
REQ-036 Prediction uses the delivered instruction (output slot or skid source) and its PC; forward branches and all others use pc+4.

Verification
REQ-037 Reset, ready=1, 1-cycle latency, stall=0: addresses 0,4,8,C issued; if_valid pulses with if_pc 0,4,8 and matching data.
REQ-038 Response for addr 0x8 while if_valid=1 and stall=1 for 3 cycles: if_pc=0x4 held, no new request, 0x8 delivered the cycle after stall drops, next request 0xC.
REQ-039 redirect_valid=1, redirect_pc=0x100 while WAIT on 0x10: 0x10 response dropped, if_valid=0, next request address 0x100.
REQ-040 imem_req_ready=0 for 4 cycles at addr 0x20: imem_addr stays 0x20, imem_req_valid stays 1, single acceptance.
REQ-041 Macro on, instr 0xFE000EE3 (beq, offset -4) at 0x40: next request 0x3C, if_pred_taken=1; macro off: next 0x44, if_pred_taken=0.
REQ-042 reset asserted during WAIT: outputs zero immediately, first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Issues one instruction memory request at a time, parks a response in a
// one-entry skid register when the IF/ID slot is stalled, and restarts on
// downstream redirects (discarding any in-flight response via a kill flag).
// Optional static BTFN prediction is enabled by defining FETCH_BTFN_PREDICT_EN.
//
// Handshakes: a memory request transfers on a cycle with
// imem_req_valid && imem_req_ready; imem_addr is held while valid && !ready
// (a redirect may retarget it). Exactly one imem_resp_valid pulse follows each
// accepted request. The output slot transfers when if_valid && !stall.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_pred_taken,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_SKID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_pred_q, if_pred_d;

    logic        slot_free;
    logic [31:0] dlv_instr;
    logic [63:0] dlv_pc;
    logic [63:0] dlv_next_pc;
    logic        dlv_pred;

    // The instruction being delivered comes from the skid register when one is
    // parked, otherwise straight from the memory response.
    assign dlv_instr = (state_q == S_SKID) ? skid_instr_q : imem_resp_data;
    assign dlv_pc    = (state_q == S_SKID) ? skid_pc_q    : fetch_pc_q;

`ifdef FETCH_BTFN_PREDICT_EN
    logic [6:0]  dlv_opcode;
    logic [63:0] j_imm;
    logic [63:0] b_imm;

    // Static prediction: JAL always taken, conditional branches taken when backward.
    always_comb begin
        dlv_opcode  = dlv_instr[6:0];
        j_imm       = {{43{dlv_instr[31]}}, dlv_instr[31], dlv_instr[19:12],
                       dlv_instr[20], dlv_instr[30:21], 1'b0};
        b_imm       = {{51{dlv_instr[31]}}, dlv_instr[31], dlv_instr[7],
                       dlv_instr[30:25], dlv_instr[11:8], 1'b0};
        dlv_pred    = 1'b0;
        dlv_next_pc = dlv_pc + 64'd4;
        if (dlv_opcode == 7'b1101111) begin
            dlv_pred    = 1'b1;
            dlv_next_pc = dlv_pc + j_imm;
        end else if (dlv_opcode == 7'b1100011 && dlv_instr[31]) begin
            dlv_pred    = 1'b1;
            dlv_next_pc = dlv_pc + b_imm;
        end
    end
`else
    assign dlv_pred    = 1'b0;
    assign dlv_next_pc = dlv_pc + 64'd4;
`endif

    assign slot_free      = !if_valid_q || !stall;
    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = fetch_pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_pred_taken  = if_pred_q;
    assign dbg_state_o    = state_q;

    // Next-state logic: redirect overrides everything, otherwise REQ/WAIT/SKID flow.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        kill_d       = kill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        if_pred_d    = if_pred_q;

        if (redirect_valid) begin
            if_valid_d = 1'b0;
            fetch_pc_d = redirect_pc;
            case (state_q)
                S_REQ: begin
                    // A request accepted this cycle is still in flight; kill it.
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            // Slot drains when consumed or empty; refilled below if data is ready.
            if (slot_free) begin
                if_valid_d = 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (slot_free) begin
                            if_valid_d = 1'b1;
                            if_instr_d = dlv_instr;
                            if_pc_d    = dlv_pc;
                            if_pred_d  = dlv_pred;
                            fetch_pc_d = dlv_next_pc;
                            state_d    = S_REQ;
                        end else begin
                            skid_instr_d = imem_resp_data;
                            skid_pc_d    = fetch_pc_q;
                            state_d      = S_SKID;
                        end
                    end
                end
                S_SKID: begin
                    if (!stall) begin
                        if_valid_d = 1'b1;
                        if_instr_d = dlv_instr;
                        if_pc_d    = dlv_pc;
                        if_pred_d  = dlv_pred;
                        fetch_pc_d = dlv_next_pc;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            kill_q       <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 64'h0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 64'h0;
            if_instr_q   <= 32'h0;
            if_pred_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            kill_q       <= kill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            if_pred_q    <= if_pred_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stall/ready/latency/redirect
// traffic, checked against a stream model of which PCs must be delivered.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0;
`ifdef FETCH_BTFN_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_pred_taken;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_pred_taken(if_pred_taken), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memory contents and reference model ----------------
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    logic [31:0] w;
    h = (a[31:0] * 32'h9E3779B1) ^ a[63:32];
    h = h ^ (h >> 15);
    w = {h[31:7], 7'b0010011};
    if (a >= 64'h1000) begin
      if (h[3:0] == 4'd0) w = {h[31:7], 7'b1101111};
      else if (h[3:0] <= 4'd2) w = {h[31:7], 7'b1100011};
    end
    if (a == 64'h40) w = 32'hFE000EE3;
    return w;
  endfunction

  function automatic logic ref_taken(input logic [31:0] ins);
    if (!PRED_EN) return 1'b0;
    if (ins[6:0] == 7'b1101111) return 1'b1;
    if (ins[6:0] == 7'b1100011 && ins[31]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic [31:0] ins);
    logic [63:0] off;
    if (!ref_taken(ins)) return pc + 64'd4;
    if (ins[6:0] == 7'b1101111) begin
      off = {43'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      if (ins[31]) off = off - 64'h200000;
    end else begin
      off = {51'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      off = off - 64'h2000;
    end
    return pc + off;
  endfunction

  // ---------------- memory driver ----------------
  int          ready_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  int          hold_cnt = 0;
  logic [63:0] hold_addr = 64'h20;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = 64'h0;

  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      mem_pend = 1'b0;
      imem_resp_valid = 1'b0;
      imem_req_ready = 1'b0;
    end else begin
      imem_resp_valid = 1'b0;
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data = mem_word(mem_addr);
          mem_pend = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (imem_req_valid && imem_addr == hold_addr && hold_cnt > 0) begin
        imem_req_ready = 1'b0;
        hold_cnt--;
      end else begin
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_pend = 1'b1;
        mem_addr = imem_addr;
        mem_cnt = $urandom_range(lat_min, lat_max) - 1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [63:0] exp_pc = RST_PC;
  logic [63:0] acc_q[$];
  logic [63:0] del_q[$];
  logic [63:0] exp_q[$];
  int          n_deliv = 0;
  logic        outstanding = 1'b0;
  logic        prev_stuck = 1'b0;
  logic [63:0] prev_addr = 64'h0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_pc = 64'h0;
  logic [31:0] prev_instr = 32'h0;

  always @(negedge clk) begin
    if (reset) begin
      exp_pc = RST_PC;
      outstanding = 1'b0;
      prev_stuck = 1'b0;
      prev_hold = 1'b0;
      acc_q.delete();
      del_q.delete();
    end else begin
      chk("one_outstanding", {63'b0, outstanding && imem_req_valid}, 64'd0);
      if (prev_stuck) begin
        chk("req_held", {63'b0, imem_req_valid}, 64'd1);
        chk("addr_stable", imem_addr, prev_addr);
      end
      if (prev_hold) begin
        chk("hold_valid", {63'b0, if_valid}, 64'd1);
        chk("hold_pc", if_pc, prev_pc);
        chk("hold_instr", {32'b0, if_instr}, {32'b0, prev_instr});
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (if_valid && !stall) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", {32'b0, if_instr}, {32'b0, mem_word(exp_pc)});
        chk("if_pred", {63'b0, if_pred_taken}, {63'b0, ref_taken(mem_word(exp_pc))});
        del_q.push_back(if_pc);
        n_deliv++;
        exp_pc = ref_next(exp_pc, mem_word(exp_pc));
      end
      if (imem_resp_valid) outstanding = 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        outstanding = 1'b1;
        acc_q.push_back(imem_addr);
      end
      prev_stuck = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr = imem_addr;
      prev_hold = if_valid && stall && !redirect_valid;
      prev_pc = if_pc;
      prev_instr = if_instr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'h0;
    hold_cnt = 0;
    repeat (3) step();
    chk("rst_if_valid", {63'b0, if_valid}, 64'd0);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_if_instr", {32'b0, if_instr}, 64'h0);
    chk("rst_pred", {63'b0, if_pred_taken}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_req_valid", {63'b0, imem_req_valid}, 64'd1);
    chk("rel_addr", imem_addr, RST_PC);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ok;
    int   n0;
    int   cnt20;

    // Straight-line fetch, 1-cycle latency, always ready.
    lat_min = 1; lat_max = 1; ready_pct = 100;
    do_reset();
    repeat (12) step();
    exp_q = '{64'h0, 64'h4, 64'h8, 64'hC};
    for (int i = 0; i < 4; i++) chk("seq_addr", acc_q[i], exp_q.pop_front());
    exp_q = '{64'h0, 64'h4, 64'h8};
    for (int i = 0; i < 3; i++) chk("seq_deliv", del_q[i], exp_q.pop_front());

    // Response for 0x8 lands while 0x4 is stalled in the slot.
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = if_valid && if_pc == 64'h4;
    end
    chk("wait_pc4", {63'b0, ok}, 64'd1);
    stall = 1'b1;
    step();
    chk("stall_pc4_a", if_pc, 64'h4);
    chk("stall_noreq_a", {63'b0, imem_req_valid}, 64'd0);
    step();
    chk("stall_pc4_b", if_pc, 64'h4);
    chk("stall_noreq_b", {63'b0, imem_req_valid}, 64'd0);
    step();
    stall = 1'b0;
    chk("stall_noreq_c", {63'b0, imem_req_valid}, 64'd0);
    step();
    chk("skid_valid", {63'b0, if_valid}, 64'd1);
    chk("skid_pc", if_pc, 64'h8);
    chk("skid_instr", {32'b0, if_instr}, {32'b0, mem_word(64'h8)});
    chk("skid_next_req", {63'b0, imem_req_valid}, 64'd1);
    chk("skid_next_addr", imem_addr, 64'hC);

    // Redirect while waiting on 0x10.
    lat_min = 3; lat_max = 3;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      step();
      ok = imem_req_valid && imem_addr == 64'h10;
    end
    chk("wait_req10", {63'b0, ok}, 64'd1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h100;
    n0 = del_q.size();
    step();
    redirect_valid = 1'b0;
    chk("redir_if_valid", {63'b0, if_valid}, 64'd0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      ok = imem_req_valid;
      if (!ok) step();
    end
    chk("redir_req", {63'b0, ok}, 64'd1);
    chk("redir_addr", imem_addr, 64'h100);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = del_q.size() > n0;
    end
    chk("redir_deliv", {63'b0, ok}, 64'd1);
    chk("redir_first_pc", del_q[n0], 64'h100);

    // Memory not ready for 4 cycles at 0x20.
    lat_min = 1; lat_max = 1;
    do_reset();
    hold_cnt = 4;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      step();
      ok = imem_req_valid && imem_addr == 64'h20;
    end
    chk("wait_req20", {63'b0, ok}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nr_valid", {63'b0, imem_req_valid}, 64'd1);
      chk("nr_addr", imem_addr, 64'h20);
    end
    repeat (6) step();
    cnt20 = 0;
    foreach (acc_q[i]) if (acc_q[i] == 64'h20) cnt20++;
    chk("nr_single_accept", 64'(cnt20), 64'd1);

    // Backward branch at 0x40.
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = if_valid && if_pc == 64'h40;
    end
    chk("wait_pc40", {63'b0, ok}, 64'd1);
    chk("br_instr", {32'b0, if_instr}, 64'hFE000EE3);
    chk("br_pred", {63'b0, if_pred_taken}, PRED_EN ? 64'd1 : 64'd0);
    chk("br_next_valid", {63'b0, imem_req_valid}, 64'd1);
    chk("br_next_addr", imem_addr, PRED_EN ? 64'h3C : 64'h44);

    // Reset while a request is outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      ok = if_valid && if_pc == 64'h4;
    end
    chk("wait_pc4_r", {63'b0, ok}, 64'd1);
    stall = 1'b1;
    step();
    chk("pre_rst_valid", {63'b0, if_valid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'b0, if_valid}, 64'd0);
    chk("mid_rst_pc", if_pc, 64'h0);
    chk("mid_rst_instr", {32'b0, if_instr}, 64'h0);
    chk("mid_rst_req", {63'b0, imem_req_valid}, 64'd1);
    chk("mid_rst_addr", imem_addr, RST_PC);
    step();
    step();
    reset = 1'b0;
    stall = 1'b0;
    #1;
    chk("post_rst_addr", imem_addr, RST_PC);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = if_valid;
    end
    chk("post_rst_deliv", {63'b0, ok}, 64'd1);
    chk("post_rst_pc", if_pc, RST_PC);

    // Randomized traffic.
    lat_min = 1; lat_max = 3; ready_pct = 70;
    do_reset();
    n0 = n_deliv;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc = 64'h1000 + 64'($urandom_range(0, 1023)) * 64'd4
                    + (($urandom_range(0, 15) == 0) ? 64'd1 : 64'd0);
      step();
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (10) step();
    chk("rand_progress", {63'b0, (n_deliv - n0) > 200}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
